ex_issue: RTL and testbench

Execute-stage issue buffer sitting between decode and the execute units (ALU, shift, branch, LSU). Holds up to two decoded instructions in a small FIFO with a valid/ready handshake on both sides. Resolves register-file staleness by forwarding the writeback result into both captured and buffered operands, selects immediate vs. rs2, and presents `funct3`/`funct7`/`op1`/`op2` to the execute units one instruction per cycle.

---
 rtl/ex_issue_pkg.sv | 43 ++++
 rtl/ex_issue_fwd.sv | 25 ++
 rtl/ex_issue.sv | 160 ++++++++++++++++
 tb/tb_ex_issue.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_issue_pkg.sv
// Shared processor defines for the execute issue stage: widths, unit/funct3 codes, entry layout.
// No logic; latency and backpressure are defined by the modules that import it.
// Shift operands keep only the low SHAMT_W bits.
package ex_issue_pkg;

    localparam int XLEN    = 32;
    localparam int RA_W    = 5;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        UNIT_ALU    = 2'd0,
        UNIT_SHIFT  = 2'd1,
        UNIT_BRANCH = 2'd2,
        UNIT_LSU    = 2'd3
    } unit_e;

    localparam logic [3:0] F3_ADD  = 4'h0;
    localparam logic [3:0] F3_SLL  = 4'h1;
    localparam logic [3:0] F3_SLT  = 4'h2;
    localparam logic [3:0] F3_SLTU = 4'h3;
    localparam logic [3:0] F3_XOR  = 4'h4;
    localparam logic [3:0] F3_SRL  = 4'h5;
    localparam logic [3:0] F3_OR   = 4'h6;
    localparam logic [3:0] F3_AND  = 4'h7;

    typedef struct packed {
        unit_e           unit;
        logic [3:0]      funct3;
        logic            funct7;
        logic [RA_W-1:0] rs1;
        logic            rs1_vld;
        logic [RA_W-1:0] rs2;
        logic            rs2_vld;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [RA_W-1:0] rd;
    } entry_t;

    function automatic logic [XLEN-1:0] shamt_mask(input logic [XLEN-1:0] v);
        return {{(XLEN-SHAMT_W){1'b0}}, v[SHAMT_W-1:0]};
    endfunction

endpackage

// File: rtl/ex_issue_fwd.sv
// Operand forwarding slice: one tag compare against the writeback bus plus select/mask.
// Purely combinational, zero latency.
// No handshake; caller decides when the result is stored.
module ex_issue_fwd
    import ex_issue_pkg::*;
(
    input  logic [RA_W-1:0] tag,
    input  logic            tag_vld,
    input  logic [XLEN-1:0] cur,
    input  logic            wb_we,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            shift_mask,
    output logic [XLEN-1:0] nxt
);

    logic            hit;
    logic [XLEN-1:0] sel;

    // x0 is hardwired zero, so a write to it must never be forwarded
    assign hit = wb_we && tag_vld && (wb_rd == tag) && (wb_rd != '0);
    assign sel = hit ? wb_data : cur;
    assign nxt = shift_mask ? shamt_mask(sel) : sel;

endmodule

// File: rtl/ex_issue.sv
// Two-entry execute issue buffer with writeback forwarding into captured and buffered operands.
// Latency: push at edge N is presented on ex_* in cycle N+1; one instruction per cycle sustained.
// Backpressure: id_ready_o/ex_valid_o decode only the count flop; head holds while ex_ready_i is low.
module ex_issue
    import ex_issue_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic            id_valid_i,
    output logic            id_ready_o,
    input  logic [1:0]      id_unit_i,
    input  logic [3:0]      id_funct3_i,
    input  logic            id_funct7_i,
    input  logic [RA_W-1:0] id_rs1_i,
    input  logic [RA_W-1:0] id_rs2_i,
    input  logic [XLEN-1:0] id_rs1_data_i,
    input  logic [XLEN-1:0] id_rs2_data_i,
    input  logic [XLEN-1:0] id_imm_i,
    input  logic            id_use_imm_i,
    input  logic [RA_W-1:0] id_rd_i,
    input  logic            wb_we_i,
    input  logic [RA_W-1:0] wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            ex_valid_o,
    input  logic            ex_ready_i,
    output logic [1:0]      ex_unit_o,
    output logic [3:0]      ex_funct3_o,
    output logic            ex_funct7_o,
    output logic [XLEN-1:0] ex_op1_o,
    output logic [XLEN-1:0] ex_op2_o,
    output logic [RA_W-1:0] ex_rd_o
);

    entry_t          ent_q [2];
    logic            head_q;
    logic [1:0]      count_q;

    logic            push;
    logic            pop;
    logic            tail;
    logic            cap_shift;
    logic [XLEN-1:0] cap_op2_raw;
    logic [XLEN-1:0] cap_op1;
    logic [XLEN-1:0] cap_op2;
    entry_t          cap_ent;
    logic [1:0]      occ;
    logic [XLEN-1:0] snp_op1 [2];
    logic [XLEN-1:0] snp_op2 [2];

    assign id_ready_o = (count_q != 2'd2);
    assign ex_valid_o = (count_q != 2'd0);
    assign push       = id_valid_i && id_ready_o;
    assign pop        = ex_valid_o && ex_ready_i;
    // With count 0 the tail is the head slot, with count 1 it is the other slot
    assign tail       = head_q ^ count_q[0];

    assign cap_shift   = (id_unit_i == UNIT_SHIFT);
    assign cap_op2_raw = id_use_imm_i ? id_imm_i : id_rs2_data_i;

    ex_issue_fwd u_cap_op1 (
        .tag        (id_rs1_i),
        .tag_vld    (1'b1),
        .cur        (id_rs1_data_i),
        .wb_we      (wb_we_i),
        .wb_rd      (wb_rd_i),
        .wb_data    (wb_data_i),
        .shift_mask (1'b0),
        .nxt        (cap_op1)
    );

    ex_issue_fwd u_cap_op2 (
        .tag        (id_rs2_i),
        .tag_vld    (!id_use_imm_i),
        .cur        (cap_op2_raw),
        .wb_we      (wb_we_i),
        .wb_rd      (wb_rd_i),
        .wb_data    (wb_data_i),
        .shift_mask (cap_shift),
        .nxt        (cap_op2)
    );

    always_comb begin
        cap_ent         = '0;
        cap_ent.unit    = unit_e'(id_unit_i);
        cap_ent.funct3  = id_funct3_i;
        cap_ent.funct7  = id_funct7_i;
        cap_ent.rs1     = id_rs1_i;
        cap_ent.rs1_vld = 1'b1;
        cap_ent.rs2     = id_rs2_i;
        cap_ent.rs2_vld = !id_use_imm_i;
        cap_ent.op1     = cap_op1;
        cap_ent.op2     = cap_op2;
        cap_ent.rd      = id_rd_i;
    end

    for (genvar i = 0; i < 2; i++) begin : g_snoop
        assign occ[i] = (count_q == 2'd2) || ((count_q == 2'd1) && (head_q == 1'(i)));

        ex_issue_fwd u_snp_op1 (
            .tag        (ent_q[i].rs1),
            .tag_vld    (ent_q[i].rs1_vld && occ[i]),
            .cur        (ent_q[i].op1),
            .wb_we      (wb_we_i),
            .wb_rd      (wb_rd_i),
            .wb_data    (wb_data_i),
            .shift_mask (1'b0),
            .nxt        (snp_op1[i])
        );

        ex_issue_fwd u_snp_op2 (
            .tag        (ent_q[i].rs2),
            .tag_vld    (ent_q[i].rs2_vld && occ[i]),
            .cur        (ent_q[i].op2),
            .wb_we      (wb_we_i),
            .wb_rd      (wb_rd_i),
            .wb_data    (wb_data_i),
            .shift_mask (ent_q[i].unit == UNIT_SHIFT),
            .nxt        (snp_op2[i])
        );
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
            ent_q   <= '{default: '0};
        end else begin
            for (int i = 0; i < 2; i++) begin
                ent_q[i].op1 <= snp_op1[i];
                ent_q[i].op2 <= snp_op2[i];
            end
            if (flush_i) begin
                count_q <= 2'd0;
                head_q  <= 1'b0;
            end else begin
                // Later write wins over the snoop update for the slot being filled
                if (push) begin
                    ent_q[tail] <= cap_ent;
                end
                if (pop) begin
                    head_q <= ~head_q;
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + 2'd1;
                    2'b01:   count_q <= count_q - 2'd1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    assign ex_unit_o   = ent_q[head_q].unit;
    assign ex_funct3_o = ent_q[head_q].funct3;
    assign ex_funct7_o = ent_q[head_q].funct7;
    assign ex_op1_o    = ent_q[head_q].op1;
    assign ex_op2_o    = ent_q[head_q].op2;
    assign ex_rd_o     = ent_q[head_q].rd;

endmodule

// File: tb/tb_ex_issue.sv
// Scoreboard bench for ex_issue: a queue model of the buffer is checked against the head every cycle.
module tb_ex_issue;
    import ex_issue_pkg::*;

    logic            clk_i = 1'b0;
    logic            rst_n_i;
    logic            flush_i;
    logic            id_valid_i;
    logic            id_ready_o;
    logic [1:0]      id_unit_i;
    logic [3:0]      id_funct3_i;
    logic            id_funct7_i;
    logic [4:0]      id_rs1_i, id_rs2_i, id_rd_i;
    logic [31:0]     id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic            id_use_imm_i;
    logic            wb_we_i;
    logic [4:0]      wb_rd_i;
    logic [31:0]     wb_data_i;
    logic            ex_valid_o;
    logic            ex_ready_i;
    logic [1:0]      ex_unit_o;
    logic [3:0]      ex_funct3_o;
    logic            ex_funct7_o;
    logic [31:0]     ex_op1_o, ex_op2_o;
    logic [4:0]      ex_rd_o;

    ex_issue dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .id_unit_i(id_unit_i),
        .id_funct3_i(id_funct3_i), .id_funct7_i(id_funct7_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
        .id_imm_i(id_imm_i), .id_use_imm_i(id_use_imm_i), .id_rd_i(id_rd_i),
        .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i), .ex_unit_o(ex_unit_o),
        .ex_funct3_o(ex_funct3_o), .ex_funct7_o(ex_funct7_o),
        .ex_op1_o(ex_op1_o), .ex_op2_o(ex_op2_o), .ex_rd_o(ex_rd_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  unit;
        logic [3:0]  f3;
        logic        f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        bit          v2;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
    } mdl_t;

    mdl_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    function automatic bit wb_hit(input logic [4:0] r);
        return wb_we_i && (wb_rd_i != 5'd0) && (wb_rd_i == r);
    endfunction

    function automatic mdl_t capture();
        mdl_t m;
        m.unit = id_unit_i;
        m.f3   = id_funct3_i;
        m.f7   = id_funct7_i;
        m.rs1  = id_rs1_i;
        m.rs2  = id_rs2_i;
        m.v2   = !id_use_imm_i;
        m.rd   = id_rd_i;
        m.op1  = wb_hit(id_rs1_i) ? wb_data_i : id_rs1_data_i;
        if (id_use_imm_i)          m.op2 = id_imm_i;
        else if (wb_hit(id_rs2_i)) m.op2 = wb_data_i;
        else                       m.op2 = id_rs2_data_i;
        if (m.unit == 2'd1) m.op2 = m.op2 & 32'h1f;
        return m;
    endfunction

    // Compare the head against the model, then advance both across one clock edge.
    task automatic cycle();
        bit   do_push, do_pop;
        mdl_t cap;
        chk("ex_valid", 32'(ex_valid_o), 32'(sb.size() != 0));
        chk("id_ready", 32'(id_ready_o), 32'(sb.size() != 2));
        if (sb.size() != 0) begin
            chk("unit",   32'(ex_unit_o),   32'(sb[0].unit));
            chk("funct3", 32'(ex_funct3_o), 32'(sb[0].f3));
            chk("funct7", 32'(ex_funct7_o), 32'(sb[0].f7));
            chk("op1",    ex_op1_o,         sb[0].op1);
            chk("op2",    ex_op2_o,         sb[0].op2);
            chk("rd",     32'(ex_rd_o),     32'(sb[0].rd));
        end
        do_push = id_valid_i && (sb.size() < 2);
        do_pop  = ex_ready_i && (sb.size() != 0);
        cap     = capture();
        @(posedge clk_i);
        if (flush_i) begin
            sb.delete();
        end else begin
            foreach (sb[i]) begin
                if (wb_hit(sb[i].rs1)) sb[i].op1 = wb_data_i;
                if (sb[i].v2 && wb_hit(sb[i].rs2))
                    sb[i].op2 = (sb[i].unit == 2'd1) ? (wb_data_i & 32'h1f) : wb_data_i;
            end
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back(cap);
        end
        @(negedge clk_i);
    endtask

    task automatic offer(input logic [1:0] unit, input logic [3:0] f3, input logic f7,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic use_imm, input logic [4:0] rd);
        id_valid_i = 1'b1; id_unit_i = unit; id_funct3_i = f3; id_funct7_i = f7;
        id_rs1_i = rs1; id_rs2_i = rs2; id_rs1_data_i = d1; id_rs2_data_i = d2;
        id_imm_i = imm; id_use_imm_i = use_imm; id_rd_i = rd;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
        wb_we_i = we; wb_rd_i = rd; wb_data_i = d;
    endtask

    initial begin
        rst_n_i = 1'b0; flush_i = 1'b0; ex_ready_i = 1'b0;
        offer(2'd0, 4'd0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        id_valid_i = 1'b0;
        set_wb(1'b0, 5'd0, 32'd0);
        repeat (2) @(negedge clk_i);
        chk("rst_ex_valid", 32'(ex_valid_o), 32'd0);
        chk("rst_id_ready", 32'(id_ready_o), 32'd1);
        chk("rst_op1", ex_op1_o, 32'd0);
        chk("rst_op2", ex_op2_o, 32'd0);
        chk("rst_rd",  32'(ex_rd_o), 32'd0);
        rst_n_i = 1'b1;
        cycle();

        // Shift immediate keeps only the shift amount
        offer(2'(UNIT_SHIFT), F3_SRL, 1'b0, 5'd1, 5'd2, 32'h8000_0000, 32'h0, 32'h23, 1'b1, 5'd3);
        cycle();
        id_valid_i = 1'b0;
        chk("srl_valid", 32'(ex_valid_o), 32'd1);
        chk("srl_op2", ex_op2_o, 32'h3);
        cycle();

        // Fill to two with execute stalled; third offer must be refused
        offer(2'(UNIT_ALU), F3_ADD, 1'b1, 5'd2, 5'd3, 32'd10, 32'd20, 32'd0, 1'b0, 5'd4);
        cycle();
        offer(2'(UNIT_LSU), F3_XOR, 1'b0, 5'd8, 5'd9, 32'd30, 32'd40, 32'd0, 1'b0, 5'd10);
        chk("full_id_ready", 32'(id_ready_o), 32'd0);
        cycle();
        id_valid_i = 1'b0;
        ex_ready_i = 1'b1;
        repeat (3) cycle();
        ex_ready_i = 1'b0;

        // Snoop into a buffered rs1; then a write to x0 must change nothing
        offer(2'(UNIT_ALU), F3_OR, 1'b0, 5'd5, 5'd6, 32'h11, 32'h22, 32'd0, 1'b0, 5'd7);
        cycle();
        id_valid_i = 1'b0;
        set_wb(1'b1, 5'd5, 32'hDEAD_BEEF);
        cycle();
        chk("snoop_op1", ex_op1_o, 32'hDEAD_BEEF);
        set_wb(1'b1, 5'd0, 32'h5555_5555);
        cycle();
        chk("x0_op1", ex_op1_o, 32'hDEAD_BEEF);
        set_wb(1'b0, 5'd0, 32'd0);
        ex_ready_i = 1'b1;
        cycle();
        ex_ready_i = 1'b0;

        // Capture-cycle forward on rs2
        set_wb(1'b1, 5'd7, 32'h1234);
        offer(2'(UNIT_BRANCH), F3_SLT, 1'b0, 5'd1, 5'd7, 32'h1, 32'h99, 32'd0, 1'b0, 5'd0);
        cycle();
        set_wb(1'b0, 5'd0, 32'd0);
        // Shift register operand snooped later must still be masked
        offer(2'(UNIT_SHIFT), F3_SLL, 1'b1, 5'd1, 5'd9, 32'h1, 32'h2, 32'd0, 1'b0, 5'd2);
        chk("fwd_op2", ex_op2_o, 32'h1234);
        cycle();
        id_valid_i = 1'b0;
        set_wb(1'b1, 5'd9, 32'hFFFF_FFE6);
        cycle();
        set_wb(1'b0, 5'd0, 32'd0);
        ex_ready_i = 1'b1;
        cycle();
        chk("shift_snoop_op2", ex_op2_o, 32'h6);
        cycle();
        ex_ready_i = 1'b0;

        // Flush with a full buffer and a simultaneous push
        offer(2'(UNIT_ALU), F3_AND, 1'b0, 5'd3, 5'd4, 32'h5, 32'h6, 32'd0, 1'b0, 5'd1);
        repeat (2) cycle();
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        id_valid_i = 1'b0;
        chk("flush_valid", 32'(ex_valid_o), 32'd0);
        chk("flush_ready", 32'(id_ready_o), 32'd1);
        cycle();

        // Random mix of pushes, stalls and writebacks
        for (int n = 0; n < 40; n++) begin
            offer(2'($urandom_range(0, 3)), 4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom,
                  $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            id_valid_i = ($urandom_range(0, 3) != 0);
            ex_ready_i = ($urandom_range(0, 3) != 0);
            set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            cycle();
        end
        id_valid_i = 1'b0; ex_ready_i = 1'b1;
        set_wb(1'b0, 5'd0, 32'd0);
        repeat (3) cycle();
        ex_ready_i = 1'b0;

        // Asynchronous reset between edges with one entry held
        offer(2'(UNIT_LSU), F3_ADD, 1'b0, 5'd1, 5'd2, 32'hAAAA_0001, 32'h3, 32'd0, 1'b0, 5'd12);
        cycle();
        id_valid_i = 1'b0;
        #2 rst_n_i = 1'b0;
        #1;
        chk("arst_valid", 32'(ex_valid_o), 32'd0);
        chk("arst_op1", ex_op1_o, 32'd0);
        chk("arst_op2", ex_op2_o, 32'd0);
        chk("arst_unit", 32'(ex_unit_o), 32'd0);
        chk("arst_rd", 32'(ex_rd_o), 32'd0);
        sb.delete();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
